// File: rtl/cache_pkg.sv
// Shared definitions for the L1 cache set array and its controller:
// request opcodes, default geometry and per-line metadata layout.
package cache_pkg;

    typedef enum logic [1:0] {
        CACHE_OP_LOOKUP = 2'd0,
        CACHE_OP_WRITE  = 2'd1,
        CACHE_OP_FLUSH  = 2'd2,
        CACHE_OP_RSVD   = 2'd3
    } cache_op_e;

    localparam int CACHE_WAYS   = 2;
    localparam int CACHE_SETS   = 2;
    localparam int CACHE_TAG_W  = 26;
    localparam int CACHE_LINE_W = 128;

    // Metadata of one line at the default tag width.
    typedef struct packed {
        logic                   valid;
        logic                   dirty;
        logic [CACHE_TAG_W-1:0] tag;
    } cache_meta_t;

    typedef enum logic {
        SWEEP_IDLE = 1'b0,
        SWEEP_RUN  = 1'b1
    } sweep_state_e;

endpackage

// File: rtl/cache_set_array_plru.sv
// Combinational tree-PLRU helper: computes the state after touching a way
// and the victim way selected by the current state.
module plru_tree #(
    parameter  int WAYS   = 2,
    localparam int WAY_W  = (WAYS > 1) ? $clog2(WAYS) : 1,
    localparam int PLRU_W = (WAYS > 1) ? WAYS - 1 : 1
) (
    input  logic [PLRU_W-1:0] state,
    input  logic [WAY_W-1:0]  touch_way,
    output logic [PLRU_W-1:0] next_state,
    output logic [WAY_W-1:0]  victim_way
);

    localparam int LEVELS = $clog2(WAYS);

    generate
        if (WAYS == 1) begin : g_single
            assign next_state = state;
            assign victim_way = '0;
        end else begin : g_tree
            // Nodes are heap-numbered from 1 at the root; node n lives in bit n-1.
            // A node value of 0 points the victim search left, 1 points right.
            int node_t;
            int node_v;
            always_comb begin
                next_state = state;
                victim_way = '0;
                node_t     = 1;
                node_v     = 1;
                for (int l = 0; l < LEVELS; l++) begin
                    next_state[node_t-1] = ~touch_way[LEVELS-1-l];
                    node_t = 2 * node_t + int'(touch_way[LEVELS-1-l]);
                    victim_way[LEVELS-1-l] = state[node_v-1];
                    node_v = 2 * node_v + int'(state[node_v-1]);
                end
            end
        end
    endgenerate

endmodule

// File: rtl/cache_set_array.sv
// N-way set-associative data/tag/valid/dirty storage with registered lookup,
// tree-PLRU replacement and a one-set-per-cycle invalidate-all sweep.
module cache_set_array
    import cache_pkg::*;
#(
    parameter  int WAYS   = CACHE_WAYS,
    parameter  int SETS   = CACHE_SETS,
    parameter  int TAG_W  = CACHE_TAG_W,
    parameter  int LINE_W = CACHE_LINE_W,
    localparam int IDX_W  = $clog2(SETS),
    localparam int WAY_W  = (WAYS > 1) ? $clog2(WAYS) : 1
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic [1:0]        req_op,
    input  logic [IDX_W-1:0]  req_index,
    input  logic [TAG_W-1:0]  req_tag,
    input  logic [WAY_W-1:0]  req_way,
    input  logic [LINE_W-1:0] req_wdata,
    input  logic              req_dirty,
    output logic              resp_valid,
    output logic              resp_hit,
    output logic [WAY_W-1:0]  resp_way,
    output logic [LINE_W-1:0] resp_data,
    output logic [TAG_W-1:0]  resp_tag,
    output logic              resp_line_valid,
    output logic              resp_line_dirty,
    output logic              busy
);

    localparam int PLRU_W = (WAYS > 1) ? WAYS - 1 : 1;
    localparam logic [WAY_W:0] WAYS_LIM = (WAY_W + 1)'(WAYS);

    typedef struct packed {
        logic             valid;
        logic             dirty;
        logic [TAG_W-1:0] tag;
    } line_meta_t;

    logic [LINE_W-1:0] data_q  [SETS][WAYS];
    logic [TAG_W-1:0]  tag_q   [SETS][WAYS];
    logic [WAYS-1:0]   valid_q [SETS];
    logic [WAYS-1:0]   dirty_q [SETS];
    logic [PLRU_W-1:0] plru_q  [SETS];

    sweep_state_e     state_q, state_d;
    logic [IDX_W-1:0] sweep_idx_q, sweep_idx_d;

    logic              resp_valid_q, resp_hit_q;
    logic [WAY_W-1:0]  resp_way_q;
    logic [LINE_W-1:0] resp_data_q;
    line_meta_t        resp_meta_q;

    logic             accept, is_lookup, is_write, is_flush, do_touch;
    logic             hit, inv_found;
    logic [WAY_W-1:0] hit_way, inv_way, sel_way, touch_way, plru_victim;
    logic [PLRU_W-1:0] plru_next;

    assign req_ready = (state_q == SWEEP_IDLE);
    assign busy      = (state_q == SWEEP_RUN);
    assign accept    = req_valid && req_ready;
    assign is_lookup = accept && (req_op == CACHE_OP_LOOKUP);
    assign is_write  = accept && (req_op == CACHE_OP_WRITE);
    assign is_flush  = accept && (req_op == CACHE_OP_FLUSH);

    // Descending scan leaves the lowest matching / lowest invalid way selected.
    always_comb begin
        hit       = 1'b0;
        hit_way   = '0;
        inv_found = 1'b0;
        inv_way   = '0;
        for (int w = WAYS - 1; w >= 0; w--) begin
            if (valid_q[req_index][w] && (tag_q[req_index][w] == req_tag)) begin
                hit     = 1'b1;
                hit_way = WAY_W'(w);
            end
            if (!valid_q[req_index][w]) begin
                inv_found = 1'b1;
                inv_way   = WAY_W'(w);
            end
        end
    end

    assign sel_way   = hit ? hit_way : (inv_found ? inv_way : plru_victim);
    assign touch_way = is_write ? req_way : hit_way;
    assign do_touch  = is_write || (is_lookup && hit);

    // One tree instance serves both touch and victim for the addressed set.
    plru_tree #(.WAYS(WAYS)) u_plru (
        .state      (plru_q[req_index]),
        .touch_way  (touch_way),
        .next_state (plru_next),
        .victim_way (plru_victim)
    );

    always_comb begin
        state_d     = state_q;
        sweep_idx_d = sweep_idx_q;
        unique case (state_q)
            SWEEP_IDLE: begin
                if (is_flush) begin
                    state_d     = SWEEP_RUN;
                    sweep_idx_d = '0;
                end
            end
            SWEEP_RUN: begin
                sweep_idx_d = sweep_idx_q + 1'b1;
                if (sweep_idx_q == IDX_W'(SETS - 1)) state_d = SWEEP_IDLE;
            end
            default: state_d = SWEEP_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_q      <= SWEEP_IDLE;
            sweep_idx_q  <= '0;
            resp_valid_q <= 1'b0;
            resp_hit_q   <= 1'b0;
            resp_way_q   <= '0;
            resp_data_q  <= '0;
            resp_meta_q  <= '0;
            for (int s = 0; s < SETS; s++) begin
                valid_q[s] <= '0;
                dirty_q[s] <= '0;
                plru_q[s]  <= '0;
            end
        end else begin
            state_q      <= state_d;
            sweep_idx_q  <= sweep_idx_d;
            resp_valid_q <= is_lookup;
            if (is_lookup) begin
                resp_hit_q        <= hit;
                resp_way_q        <= sel_way;
                resp_data_q       <= data_q[req_index][sel_way];
                resp_meta_q.valid <= valid_q[req_index][sel_way];
                resp_meta_q.dirty <= dirty_q[req_index][sel_way];
                resp_meta_q.tag   <= tag_q[req_index][sel_way];
            end
            if (is_write) begin
                valid_q[req_index][req_way] <= 1'b1;
                dirty_q[req_index][req_way] <= req_dirty;
            end
            if (do_touch) plru_q[req_index] <= plru_next;
            if (state_q == SWEEP_RUN) begin
                valid_q[sweep_idx_q] <= '0;
                dirty_q[sweep_idx_q] <= '0;
                plru_q[sweep_idx_q]  <= '0;
            end
        end
    end

    // Line payload and tags survive reset and flush; only metadata is cleared.
    always_ff @(posedge clk) begin
        if (is_write) begin
            data_q[req_index][req_way] <= req_wdata;
            tag_q[req_index][req_way]  <= req_tag;
        end
    end

    always_ff @(posedge clk) begin
        if (reset_n && is_write) begin
            assert ({1'b0, req_way} < WAYS_LIM);
        end
    end

    assign resp_valid      = resp_valid_q;
    assign resp_hit        = resp_hit_q;
    assign resp_way        = resp_way_q;
    assign resp_data       = resp_data_q;
    assign resp_tag        = resp_meta_q.tag;
    assign resp_line_valid = resp_meta_q.valid;
    assign resp_line_dirty = resp_meta_q.dirty;

endmodule

// File: tb/tb_cache_set_array.sv
// Self-checking bench for cache_set_array (4 ways, 8 sets): directed table,
// flush/reset corner sequences, then random traffic against a timestamp model.
module tb_cache_set_array;

    localparam int WAYS   = 4;
    localparam int SETS   = 8;
    localparam int TAG_W  = 26;
    localparam int LINE_W = 128;
    localparam int IDX_W  = 3;
    localparam int WAY_W  = 2;

    logic              clk = 1'b0;
    logic              reset_n;
    logic              req_valid, req_ready;
    logic [1:0]        req_op;
    logic [IDX_W-1:0]  req_index;
    logic [TAG_W-1:0]  req_tag;
    logic [WAY_W-1:0]  req_way;
    logic [LINE_W-1:0] req_wdata;
    logic              req_dirty;
    logic              resp_valid, resp_hit;
    logic [WAY_W-1:0]  resp_way;
    logic [LINE_W-1:0] resp_data;
    logic [TAG_W-1:0]  resp_tag;
    logic              resp_line_valid, resp_line_dirty, busy;

    cache_set_array #(.WAYS(WAYS), .SETS(SETS), .TAG_W(TAG_W), .LINE_W(LINE_W)) dut (
        .clk(clk), .reset_n(reset_n), .req_valid(req_valid), .req_ready(req_ready),
        .req_op(req_op), .req_index(req_index), .req_tag(req_tag), .req_way(req_way),
        .req_wdata(req_wdata), .req_dirty(req_dirty), .resp_valid(resp_valid),
        .resp_hit(resp_hit), .resp_way(resp_way), .resp_data(resp_data),
        .resp_tag(resp_tag), .resp_line_valid(resp_line_valid),
        .resp_line_dirty(resp_line_dirty), .busy(busy)
    );

    always #5 clk = ~clk;

    int n_vec = 0;
    int n_err = 0;

    // Reference model: per-line contents plus last-touch timestamps.
    bit                mv    [SETS][WAYS];
    bit                md    [SETS][WAYS];
    bit                known [SETS][WAYS];
    logic [TAG_W-1:0]  mt    [SETS][WAYS];
    logic [LINE_W-1:0] mdat  [SETS][WAYS];
    longint            ts    [SETS][WAYS];
    longint            now = 0;
    bit                last_hit = 1'b0;
    int                last_way = 0;

    typedef struct {
        logic [1:0]        op;
        int                idx;
        logic [TAG_W-1:0]  tag;
        int                way;
        logic [LINE_W-1:0] data;
        bit                dirty;
        bit                chk;
        bit                e_hit;
        int                e_way;
        bit                e_valid;
        bit                e_dirty;
        bit                chk_td;
        logic [TAG_W-1:0]  e_tag;
        logic [LINE_W-1:0] e_data;
    } vec_t;

    vec_t tbl[$];

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, required %0h", name, act, exp);
        end
    endtask

    function automatic void model_clear();
        for (int s = 0; s < SETS; s++)
            for (int w = 0; w < WAYS; w++) begin
                mv[s][w] = 1'b0;
                md[s][w] = 1'b0;
                ts[s][w] = 0;
            end
    endfunction

    // Tree-PLRU expressed through recency: descend into the half (then way)
    // whose most recent touch is older; untouched ties resolve to the left.
    function automatic int model_victim(input int s);
        longint l, r;
        l = (ts[s][0] > ts[s][1]) ? ts[s][0] : ts[s][1];
        r = (ts[s][2] > ts[s][3]) ? ts[s][2] : ts[s][3];
        if (l > r) return (ts[s][2] > ts[s][3]) ? 3 : 2;
        return (ts[s][0] > ts[s][1]) ? 1 : 0;
    endfunction

    function automatic void model_lookup(input int s, input logic [TAG_W-1:0] tag,
                                         output bit h, output int way);
        h = 1'b0;
        way = -1;
        for (int w = 0; w < WAYS; w++)
            if (!h && mv[s][w] && mt[s][w] == tag) begin h = 1'b1; way = w; end
        if (!h)
            for (int w = 0; w < WAYS; w++)
                if (way < 0 && !mv[s][w]) way = w;
        if (way < 0) way = model_victim(s);
    endfunction

    task automatic apply(input bit vld, input logic [1:0] op, input int idx,
                         input logic [TAG_W-1:0] tag, input int way,
                         input logic [LINE_W-1:0] data, input bit dirty);
        bit is_lk;
        bit e_hit;
        int e_way;
        is_lk = vld && (op == 2'd0);
        chk("req_ready_idle", 128'(req_ready), 128'(1));
        req_valid = vld;
        req_op    = op;
        req_index = IDX_W'(idx);
        req_tag   = tag;
        req_way   = WAY_W'(way);
        req_wdata = data;
        req_dirty = dirty;
        e_hit = 1'b0;
        e_way = 0;
        if (is_lk) model_lookup(idx, tag, e_hit, e_way);
        @(posedge clk);
        #1;
        req_valid = 1'b0;
        chk("resp_valid", 128'(resp_valid), 128'(is_lk));
        if (is_lk) begin
            chk("resp_hit", 128'(resp_hit), 128'(e_hit));
            chk("resp_way", 128'(resp_way), 128'(e_way));
            chk("resp_line_valid", 128'(resp_line_valid), 128'(mv[idx][e_way]));
            chk("resp_line_dirty", 128'(resp_line_dirty), 128'(md[idx][e_way]));
            if (known[idx][e_way]) begin
                chk("resp_tag", 128'(resp_tag), 128'(mt[idx][e_way]));
                chk("resp_data", resp_data, mdat[idx][e_way]);
            end
            if (e_hit) ts[idx][e_way] = ++now;
            last_hit = e_hit;
            last_way = e_way;
        end else begin
            chk("resp_hit_hold", 128'(resp_hit), 128'(last_hit));
            chk("resp_way_hold", 128'(resp_way), 128'(last_way));
            if (vld && op == 2'd1) begin
                mv[idx][way]    = 1'b1;
                md[idx][way]    = dirty;
                mt[idx][way]    = tag;
                mdat[idx][way]  = data;
                known[idx][way] = 1'b1;
                ts[idx][way]    = ++now;
            end
        end
    endtask

    task automatic do_flush();
        int cnt;
        chk("req_ready_flush", 128'(req_ready), 128'(1));
        req_valid = 1'b1;
        req_op    = 2'd2;
        @(posedge clk);
        #1;
        // Keep a lookup pending: it must not be taken while the sweep runs.
        req_op  = 2'd0;
        req_tag = '0;
        cnt = 0;
        while (busy && cnt < 100) begin
            chk("ready_low_busy", 128'(req_ready), 128'(0));
            cnt++;
            @(posedge clk);
            #1;
            chk("no_resp_busy", 128'(resp_valid), 128'(0));
        end
        req_valid = 1'b0;
        chk("busy_cycles", 128'(cnt), 128'(SETS));
        model_clear();
    endtask

    function automatic vec_t wr(input int idx, input int way, input logic [TAG_W-1:0] tag,
                                input logic [LINE_W-1:0] data, input bit dirty);
        vec_t v;
        v = '{op: 2'd1, idx: idx, tag: tag, way: way, data: data, dirty: dirty,
              chk: 1'b0, e_hit: 1'b0, e_way: 0, e_valid: 1'b0, e_dirty: 1'b0,
              chk_td: 1'b0, e_tag: '0, e_data: '0};
        return v;
    endfunction

    function automatic vec_t lk(input int idx, input logic [TAG_W-1:0] tag, input bit h,
                                input int w, input bit vl, input bit dt, input bit ctd,
                                input logic [TAG_W-1:0] etag, input logic [LINE_W-1:0] edata);
        vec_t v;
        v = '{op: 2'd0, idx: idx, tag: tag, way: 0, data: '0, dirty: 1'b0,
              chk: 1'b1, e_hit: h, e_way: w, e_valid: vl, e_dirty: dt,
              chk_td: ctd, e_tag: etag, e_data: edata};
        return v;
    endfunction

    initial begin
        vec_t v;
        reset_n   = 1'b0;
        req_valid = 1'b0;
        req_op    = '0;
        req_index = '0;
        req_tag   = '0;
        req_way   = '0;
        req_wdata = '0;
        req_dirty = 1'b0;
        for (int s = 0; s < SETS; s++)
            for (int w = 0; w < WAYS; w++) known[s][w] = 1'b0;
        model_clear();

        repeat (2) @(posedge clk);
        #1;
        chk("rst_resp_valid", 128'(resp_valid), 128'(0));
        chk("rst_resp_hit", 128'(resp_hit), 128'(0));
        chk("rst_resp_way", 128'(resp_way), 128'(0));
        chk("rst_resp_data", resp_data, 128'(0));
        chk("rst_resp_tag", 128'(resp_tag), 128'(0));
        chk("rst_line_valid", 128'(resp_line_valid), 128'(0));
        chk("rst_line_dirty", 128'(resp_line_dirty), 128'(0));
        chk("rst_busy", 128'(busy), 128'(0));
        chk("rst_ready", 128'(req_ready), 128'(1));
        reset_n = 1'b1;

        tbl.push_back(lk(0, 26'h5, 0, 0, 0, 0, 0, '0, '0));
        tbl.push_back(wr(1, 1, 26'h3, 128'hDEAD, 1));
        tbl.push_back(lk(1, 26'h3, 1, 1, 1, 1, 1, 26'h3, 128'hDEAD));
        tbl.push_back(wr(0, 0, 26'hA, 128'h111, 0));
        tbl.push_back(wr(0, 1, 26'hB, 128'h222, 1));
        tbl.push_back(wr(0, 2, 26'hC, 128'h333, 0));
        tbl.push_back(wr(0, 3, 26'hD, 128'h444, 1));
        tbl.push_back(lk(0, 26'hA, 1, 0, 1, 0, 1, 26'hA, 128'h111));
        tbl.push_back(lk(0, 26'hE, 0, 2, 1, 0, 1, 26'hC, 128'h333));
        for (int w = 0; w < WAYS; w++) tbl.push_back(wr(2, w, 26'h10 + w, 128'h20 + w, 0));
        tbl.push_back(lk(2, 26'h99, 0, 0, 1, 0, 1, 26'h10, 128'h20));
        tbl.push_back(lk(2, 26'h10, 1, 0, 1, 0, 1, 26'h10, 128'h20));
        tbl.push_back(lk(2, 26'h99, 0, 2, 1, 0, 1, 26'h12, 128'h22));
        tbl.push_back(wr(3, 1, 26'h7, 128'h71, 0));
        tbl.push_back(wr(3, 2, 26'h7, 128'h72, 1));
        tbl.push_back(lk(3, 26'h7, 1, 1, 1, 0, 1, 26'h7, 128'h71));
        tbl.push_back(lk(3, 26'h8, 0, 0, 0, 0, 0, '0, '0));
        v = wr(3, 0, 26'h8, 128'h80, 1);
        v.op = 2'd3;
        tbl.push_back(v);
        tbl.push_back(lk(3, 26'h8, 0, 0, 0, 0, 0, '0, '0));
        tbl.push_back(wr(1, 1, 26'h3, 128'hBEEF, 0));
        tbl.push_back(lk(1, 26'h3, 1, 1, 1, 0, 1, 26'h3, 128'hBEEF));

        foreach (tbl[i]) begin
            v = tbl[i];
            apply(1'b1, v.op, v.idx, v.tag, v.way, v.data, v.dirty);
            if (v.chk) begin
                chk($sformatf("tbl%0d_hit", i), 128'(resp_hit), 128'(v.e_hit));
                chk($sformatf("tbl%0d_way", i), 128'(resp_way), 128'(v.e_way));
                chk($sformatf("tbl%0d_lvalid", i), 128'(resp_line_valid), 128'(v.e_valid));
                chk($sformatf("tbl%0d_ldirty", i), 128'(resp_line_dirty), 128'(v.e_dirty));
                if (v.chk_td) begin
                    chk($sformatf("tbl%0d_tag", i), 128'(resp_tag), 128'(v.e_tag));
                    chk($sformatf("tbl%0d_data", i), resp_data, v.e_data);
                end
            end
        end

        // Fill every line, flush, then every line must read back invalid.
        for (int s = 0; s < SETS; s++)
            for (int w = 0; w < WAYS; w++)
                apply(1'b1, 2'd1, s, TAG_W'($urandom_range(0, 15)), w,
                      {$urandom, $urandom, $urandom, $urandom}, 1'($urandom));
        do_flush();
        for (int s = 0; s < SETS; s++) begin
            apply(1'b1, 2'd0, s, TAG_W'($urandom_range(0, 15)), 0, '0, 1'b0);
            chk("post_flush_miss", 128'(resp_hit), 128'(0));
            chk("post_flush_lvalid", 128'(resp_line_valid), 128'(0));
        end

        // Reset in the second sweep cycle aborts the sweep cleanly.
        for (int w = 0; w < WAYS; w++) apply(1'b1, 2'd1, 7, 26'h55, w, 128'h5A5A, 1'b1);
        req_valid = 1'b1;
        req_op    = 2'd2;
        @(posedge clk);
        #1;
        req_valid = 1'b0;
        @(posedge clk);
        #1;
        chk("mid_sweep_busy", 128'(busy), 128'(1));
        reset_n = 1'b0;
        @(posedge clk);
        #1;
        reset_n = 1'b1;
        chk("abort_busy", 128'(busy), 128'(0));
        chk("abort_ready", 128'(req_ready), 128'(1));
        chk("abort_resp_valid", 128'(resp_valid), 128'(0));
        model_clear();
        last_hit = 1'b0;
        last_way = 0;
        apply(1'b1, 2'd0, 7, 26'h55, 0, '0, 1'b0);
        chk("abort_lvalid", 128'(resp_line_valid), 128'(0));

        for (int n = 0; n < 400; n++) begin
            int r;
            r = $urandom_range(0, 99);
            if (r < 45)
                apply(1'b1, 2'd0, $urandom_range(0, SETS - 1), TAG_W'($urandom_range(0, 5)), 0, '0, 1'b0);
            else if (r < 85)
                apply(1'b1, 2'd1, $urandom_range(0, SETS - 1), TAG_W'($urandom_range(0, 5)),
                      $urandom_range(0, WAYS - 1), {$urandom, $urandom, $urandom, $urandom}, 1'($urandom));
            else if (r < 93)
                apply(1'b0, 2'($urandom), 0, '0, 0, '0, 1'b0);
            else if (r < 98)
                apply(1'b1, 2'd3, $urandom_range(0, SETS - 1), '0, 0, '0, 1'b0);
            else
                do_flush();
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
